// File: rtl/pipe_adder.sv
// pipe_adder: carry-chain pipelined adder with valid/ready flow control.
// The carry chain is split into STAGES chunks of WIDTH/STAGES bits. Each stage
// adds one chunk and registers its carry for the next stage. Untouched high
// operand chunks travel with the beat, and finished low sum chunks ride along
// so that every bit of the result leaves the final stage aligned.
// Optional feature: define PIPE_ADDER_SAT_EN for signed saturation of sum.
// When it is defined, cout and ovf still describe the raw add.
module pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;

    // The pipeline state. The registers of the last stage are the outputs.
    logic             vld_r [STAGES];
    logic [WIDTH-1:0] a_r   [STAGES];
    logic [WIDTH-1:0] b_r   [STAGES];
    logic [WIDTH-1:0] ps_r  [STAGES];
    logic             c_r   [STAGES];
    logic             ovf_r;

    // The next-state value of each stage.
    logic             nvld_s [STAGES];
    logic [WIDTH-1:0] na_s   [STAGES];
    logic [WIDTH-1:0] nb_s   [STAGES];
    logic [WIDTH-1:0] nps_s  [STAGES];
    logic             nc_s   [STAGES];
    logic             novf_s;
    logic             adv_s;

    // The whole pipe moves together. It stalls only when the result is held and the consumer is not ready.
    always_comb begin
        adv_s    = !vld_r[STAGES-1] || out_ready;
        in_ready = adv_s && !rst;
    end

    // Each stage adds its own chunk, with the carry that the previous stage registered.
    always_comb begin : stage_comb
        logic [WIDTH-1:0] sa_v;
        logic [WIDTH-1:0] sb_v;
        logic [WIDTH-1:0] sp_v;
        logic             sc_v;
        logic             sv_v;
        logic [CHUNK:0]   ch_v;
        int               idx_v;
        nvld_s = '{default: 1'b0};
        na_s   = '{default: {WIDTH{1'b0}}};
        nb_s   = '{default: {WIDTH{1'b0}}};
        nps_s  = '{default: {WIDTH{1'b0}}};
        nc_s   = '{default: 1'b0};
        novf_s = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            idx_v = (k > 0) ? (k - 1) : 0;
            if (k == 0) begin
                sa_v = a;
                sb_v = b;
                sp_v = {WIDTH{1'b0}};
                sc_v = cin;
                sv_v = in_valid;
            end else begin
                sa_v = a_r[idx_v];
                sb_v = b_r[idx_v];
                sp_v = ps_r[idx_v];
                sc_v = c_r[idx_v];
                sv_v = vld_r[idx_v];
            end
            ch_v = {1'b0, sa_v[k*CHUNK +: CHUNK]} + {1'b0, sb_v[k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, sc_v};
            nps_s[k]                   = sp_v;
            nps_s[k][k*CHUNK +: CHUNK] = ch_v[CHUNK-1:0];
            nc_s[k]                    = ch_v[CHUNK];
            na_s[k]                    = sa_v;
            nb_s[k]                    = sb_v;
            nvld_s[k]                  = sv_v;
        end
        // The carry into the MSB can be recovered from the MSB bits of a, b and the sum.
        novf_s = (na_s[STAGES-1][WIDTH-1] ^ nb_s[STAGES-1][WIDTH-1] ^ nps_s[STAGES-1][WIDTH-1])
               ^ nc_s[STAGES-1];
`ifdef PIPE_ADDER_SAT_EN
        if (novf_s) begin
            if (na_s[STAGES-1][WIDTH-1]) begin
                nps_s[STAGES-1] = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                nps_s[STAGES-1] = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end else begin
            nps_s[STAGES-1] = nps_s[STAGES-1];
        end
`endif
    end

    // Registers for every stage. Reset clears them, adv moves all stages together, otherwise they hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_r[k] <= 1'b0;
                a_r[k]   <= {WIDTH{1'b0}};
                b_r[k]   <= {WIDTH{1'b0}};
                ps_r[k]  <= {WIDTH{1'b0}};
                c_r[k]   <= 1'b0;
            end
            ovf_r <= 1'b0;
        end else if (adv_s) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_r[k] <= nvld_s[k];
                a_r[k]   <= na_s[k];
                b_r[k]   <= nb_s[k];
                ps_r[k]  <= nps_s[k];
                c_r[k]   <= nc_s[k];
            end
            ovf_r <= novf_s;
        end
    end

    assign out_valid = vld_r[STAGES-1];
    assign sum       = ps_r[STAGES-1];
    assign cout      = c_r[STAGES-1];
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipe_adder.sv
// Testbench for pipe_adder. A directed vector table is checked on three
// pipeline depths (4, 1 and 16 stages). Random traffic with a random out_ready
// is checked on the 4-stage instance. The bench also checks reset in the
// middle of operation.
module tb_pipe_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_valid_x;
    logic        out_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;

    logic        in_ready,  out_valid,  cout,  ovf;
    logic [15:0] sum;
    logic        ir1, ov1, co1, of1;
    logic [15:0] s1;
    logic        ir16, ov16, co16, of16;
    logic [15:0] s16;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum_wrap;
        logic [15:0] sum_sat;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t tbl [7];

    pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf));

    pipe_adder #(.WIDTH(16), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_x), .in_ready(ir1),
        .a(a), .b(b), .cin(cin), .out_valid(ov1), .out_ready(out_ready),
        .sum(s1), .cout(co1), .ovf(of1));

    pipe_adder #(.WIDTH(16), .STAGES(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid_x), .in_ready(ir16),
        .a(a), .b(b), .cin(cin), .out_valid(ov16), .out_ready(out_ready),
        .sum(s16), .cout(co16), .ovf(of16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Returns {valid, cout, ovf, sum} of instance d (0: 4 stages, 1: 1 stage, 2: 16 stages).
    function automatic logic [18:0] peek(input int d);
        case (d)
            0:       return {out_valid, cout, ovf, sum};
            1:       return {ov1, co1, of1, s1};
            default: return {ov16, co16, of16, s16};
        endcase
    endfunction

    // Reference result {cout, ovf, sum}, computed with plain integer arithmetic.
    function automatic logic [17:0] ref_model(input logic [15:0] x, input logic [15:0] y,
                                              input logic c);
        int unsigned us;
        int          sx, sy, r;
        logic [15:0] w;
        logic        co, ov;
        us = 32'(x) + 32'(y) + 32'(c);
        sx = $signed(x);
        sy = $signed(y);
        r  = sx + sy + int'(c);
        w  = us[15:0];
        co = (us > 32'd65535);
        ov = (r > 32767) || (r < -32768);
`ifdef PIPE_ADDER_SAT_EN
        if (ov) w = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
        return {co, ov, w};
    endfunction

    task automatic apply_vec(input vec_t v, input string tag);
        logic [18:0] r;
        logic [15:0] es;
        int          lat;
`ifdef PIPE_ADDER_SAT_EN
        es = v.sum_sat;
`else
        es = v.sum_wrap;
`endif
        @(posedge clk); #1;
        a = v.a; b = v.b; cin = v.cin;
        in_valid = 1'b1; in_valid_x = 1'b1; out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b0; in_valid_x = 1'b0;
            for (int d = 0; d < 3; d++) begin
                lat = (d == 0) ? 4 : ((d == 1) ? 1 : 16);
                r = peek(d);
                chk($sformatf("%s_d%0d_valid_c%0d", tag, d, k), r[18], (k == lat));
                if (k == lat) begin
                    chk($sformatf("%s_d%0d_sum", tag, d), r[15:0], es);
                    chk($sformatf("%s_d%0d_cout", tag, d), r[17], v.cout);
                    chk($sformatf("%s_d%0d_ovf", tag, d), r[16], v.ovf);
                end
            end
        end
    endtask

    initial begin
        logic [17:0] q [$];
        logic [17:0] held_val;
        logic        held;
        logic        seen;
        int          acc;
        vec_t        v;

        tbl[0] = '{16'h1234, 16'h0FED, 1'b1, 16'h2222, 16'h2222, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
        tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1};
        tbl[4] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
        tbl[5] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[6] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 16'h0100, 1'b0, 1'b0};

        // Reset. A beat presented while rst is high must be discarded.
        rst = 1'b1; in_valid = 1'b1; in_valid_x = 1'b1; out_ready = 1'b1;
        a = 16'h0101; b = 16'h0202; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        rst = 1'b0; in_valid = 1'b0; in_valid_x = 1'b0;
        chk("rst_sum", sum, 0);
        chk("rst_cout_ovf", {cout, ovf}, 0);
        chk("rst_outs_1_16", {ov1, s1, co1, of1, ov16, s16, co16, of16}, 0);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid || ov1 || ov16) seen = 1'b1;
        end
        chk("rst_discard", seen, 0);

        // Directed vectors on every pipeline depth.
        for (int i = 0; i < 7; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

        // Random traffic with a random out_ready, checked against the model.
        acc = 0; held = 1'b0; held_val = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            if (held) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", {cout, ovf, sum}, held_val);
            end
            out_ready = ($urandom_range(0, 1) == 1);
            in_valid  = (acc < 100) && ($urandom_range(0, 7) != 0);
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            #1;
            chk("in_ready_rule", in_ready, (!out_valid || out_ready));
            if (in_valid && in_ready) begin
                q.push_back(ref_model(a, b, cin));
                acc++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("spurious_beat", 1, 0);
                else chk("rand_beat", {cout, ovf, sum}, q.pop_front());
            end
            held     = out_valid && !out_ready;
            held_val = {cout, ovf, sum};
            if (acc == 100 && q.size() == 0 && !out_valid) break;
        end
        chk("rand_drain", (acc == 100) && (q.size() == 0), 1);

        // Reset while three beats are in flight.
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            a = 16'h1111 * 16'(i); b = 16'h0101; cin = 1'b0; in_valid = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_emerge", seen, 0);
        v = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 16'h0002, 1'b0, 1'b0};
        apply_vec(v, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
